// File: rtl/match_pkg.sv
// Shared types for the match arbiter: FSM state encoding and default word geometry.
package match_pkg;

    localparam int WORD_LENGTH_DEF = 3;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int WORD_W_DEF      = WORD_LENGTH_DEF * DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef logic [WORD_W_DEF-1:0] word_t;

endpackage

// File: rtl/match_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    int idx;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/match_arbiter.sv
// Shares one matcher engine among NUM_REQ requesters with round-robin grant.
// Define MATCH_TIMEOUT_EN to compile in the WAIT watchdog (TIMEOUT cycles).
module match_arbiter
    import match_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int TIMEOUT     = 64,
    localparam int WORD_W     = WORD_LENGTH * DATA_WIDTH,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WORD_W-1:0]   req_word,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_found,
    output logic                        rsp_timeout,
    output logic                        m_cs,
    output logic [WORD_W-1:0]           m_word,
    input  logic                        m_done,
    input  logic                        m_found
);

    state_e              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id_q;
    logic [WORD_W-1:0]   word_q;
    logic [NUM_REQ-1:0]  win;
    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic                grant_go;
    logic                expired;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .gnt   (win),
        .valid (win_vld)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win[i]) win_id = ID_W'(i);
    end

    // A matcher still showing m_done from the last search is not rearmed yet.
    assign grant_go  = (state == IDLE) && win_vld && !m_done;
    assign gnt       = (grant_go && rst_n) ? win : '0;
    assign rsp_valid = (state == RESP);
    assign m_cs      = (state == ISSUE) || (state == WAIT);
    assign m_word    = word_q;

`ifdef MATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               wait_cnt <= '0;
        else if (state == WAIT)   wait_cnt <= wait_cnt + 1'b1;
        else                      wait_cnt <= '0;
    end

    assign expired = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect without the watchdog; WAIT is unbounded.
    assign expired = 1'b0 & (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            id_q        <= '0;
            word_q      <= '0;
            rsp_id      <= '0;
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_go) begin
                    id_q   <= win_id;
                    word_q <= req_word[win_id*WORD_W +: WORD_W];
                    state  <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // m_done wins over a watchdog expiry in the same cycle.
                    if (m_done) begin
                        rsp_id      <= id_q;
                        rsp_found   <= m_found;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (expired) begin
                        rsp_id      <= id_q;
                        rsp_found   <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_arbiter.sv
// Randomized bench for match_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_match_arbiter;
    import match_pkg::*;

    localparam int N  = 4;
    localparam int WL = 3;
    localparam int DW = 8;
    localparam int WW = WL * DW;
    localparam int TO = 8;
`ifdef MATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*WW-1:0] req_word = '0;
    logic            m_done = 1'b0;
    logic            m_found = 1'b0;
    logic [N-1:0]    gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_found;
    logic            rsp_timeout;
    logic            m_cs;
    logic [WW-1:0]   m_word;

    always #5 clk = ~clk;

    match_arbiter #(.NUM_REQ(N), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_word(req_word), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_found(rsp_found),
        .rsp_timeout(rsp_timeout), .m_cs(m_cs), .m_word(m_word),
        .m_done(m_done), .m_found(m_found)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Model: one transaction in flight; md_age counts cycles since the grant cycle.
    bit            md_busy, md_resp;
    int            md_age, md_ptr, md_id, md_gid;
    logic [WW-1:0] md_word;
    int            md_rid;
    bit            md_rfound, md_rto;

    logic [N-1:0]  obs_gnt;
    bit            obs_rv;
    int            gcyc, lat, dly;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic bit in_wait();
        return md_busy && !md_resp && md_age >= 1;
    endfunction

    task automatic model_reset();
        md_busy = 0; md_resp = 0; md_age = 0; md_ptr = 0; md_id = 0; md_gid = -1;
        md_word = '0; md_rid = 0; md_rfound = 0; md_rto = 0;
    endtask

    task automatic eval_cycle();
        logic [N-1:0] eg;
        bit ecs, ev;
        int w;
        eg = '0; ecs = 0; ev = 0; w = -1; md_gid = -1;
        if (md_resp) ev = 1;
        else if (md_busy) ecs = 1;
        else if (!m_done) begin
            w = rr_pick(req, md_ptr);
            if (w >= 0) eg[w] = 1'b1;
        end
        check("gnt", gnt, eg);
        check("m_cs", m_cs, ecs);
        check("rsp_valid", rsp_valid, ev);
        check("m_word", m_word, md_word);
        check("rsp_id", rsp_id, md_rid);
        check("rsp_found", rsp_found, md_rfound);
        check("rsp_timeout", rsp_timeout, md_rto);
        if (md_resp) begin
            md_resp = 0; md_busy = 0; md_ptr = (md_id + 1) % N;
        end else if (md_busy) begin
            if (md_age >= 1) begin
                if (m_done) begin
                    md_rid = md_id; md_rfound = m_found; md_rto = 0; md_resp = 1;
                end else if (TO_EN && (md_age - 1) == TO - 1) begin
                    md_rid = md_id; md_rfound = 0; md_rto = 1; md_resp = 1;
                end
            end
            md_age++;
        end else if (w >= 0) begin
            md_busy = 1; md_age = 0; md_id = w; md_gid = w;
            md_word = req_word[w*WW +: WW];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        obs_gnt = gnt;
        obs_rv  = rsp_valid;
        eval_cycle();
        if (obs_gnt != 0) gcyc = cyc;
        if (obs_rv) lat = cyc - gcyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_m_cs", m_cs, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        model_reset();
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_m_word", m_word, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_found", rsp_found, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives m_done after d WAIT cycles and steps until the DUT responds.
    task automatic run_until_rsp(input int d);
        bit seen;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            m_done = in_wait() && (md_age - 1 >= d);
            tick();
            if (md_gid >= 0) req[md_gid] = 1'b0;
            seen = obs_rv;
        end
        if (!seen) check("rsp_bound", 0, 1);
        m_done = 1'b0;
    endtask

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 3);
        if (TO_EN && r == 0) return 1000;
        if (TO_EN && r == 1) return TO - 1;
        return $urandom_range(0, 6);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        word_t hel;
        int order[$];
        int ng;
        hel = 24'h48656C;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single request, search completes after 5 WAIT cycles.
        req = 4'b0001;
        req_word[0 +: WW] = hel;
        m_found = 1'b1;
        tick();
        req = '0;
        check("t1_gnt", obs_gnt, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            req_word[0 +: WW] = WW'($urandom);
        end
        run_until_rsp(5);
        check("t1_latency", lat, 8);
        check("t1_rsp_id", rsp_id, 0);
        check("t1_rsp_found", rsp_found, 1);
        check("t1_m_word_hold", m_word, hel);

        // Contention: all four hold requests, re-raise the cycle after grant.
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            m_done  = in_wait();
            m_found = $urandom_range(0, 1);
            tick();
            req = 4'b1111;
            if (md_gid >= 0) req[md_gid] = 1'b0;
            for (int i = 0; i < N; i++)
                if (obs_gnt[i]) order.push_back(i);
        end
        check("t2_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check("t2_order", order[i], i % N);

        // Rearm: m_done stays high past the response, no grant until it drops.
        req = 4'b1111;
        run_until_rsp(0);
        req = 4'b1111;
        m_done = 1'b1;
        ng = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (obs_gnt != 0) ng++;
        end
        check("t3_no_gnt", ng, 0);
        m_done = 1'b0;
        tick();
        check("t3_gnt_after", obs_gnt, 4'b0010);
        req = 4'b1101;
        run_until_rsp(1);

        // Reset mid-WAIT after the pointer has advanced to 3.
        do_reset();
        req = 4'b0100;
        tick();
        req = '0;
        run_until_rsp(0);
        req = 4'b1000;
        tick();
        req = '0;
        for (int c = 0; c < 3; c++) tick();
        check("t4_in_wait_cs", m_cs, 1);
        do_reset();
        req = 4'b1111;
        tick();
        check("t4_first_gnt", obs_gnt, 4'b0001);
        req = 4'b1110;
        run_until_rsp(0);

`ifdef MATCH_TIMEOUT_EN
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        run_until_rsp(1000);
        check("t5_to_latency", lat, 3 + TO - 1);
        check("t5_to_flag", rsp_timeout, 1);
        check("t5_to_found", rsp_found, 0);
        req = 4'b0010;
        m_found = 1'b1;
        tick();
        req = '0;
        run_until_rsp(TO - 1);
        check("t5_same_latency", lat, 3 + TO - 1);
        check("t5_same_flag", rsp_timeout, 0);
        check("t5_same_found", rsp_found, 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        dly = pick_dly();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
                if ($urandom_range(0, 2) == 0) req_word[i*WW +: WW] = WW'($urandom);
            end
            m_found = $urandom_range(0, 1);
            if (in_wait())                 m_done = (md_age - 1 >= dly);
            else if (!md_busy && !md_resp) m_done = ($urandom_range(0, 7) == 0);
            else                           m_done = $urandom_range(0, 1);
            tick();
            if (md_gid >= 0) begin
                req[md_gid] = 1'b0;
                dly = pick_dly();
            end
            if (c == 1500) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
